segment_scan_decoder: RTL and testbench
=======================================

# segment_scan_decoder

- Receive-side counterpart of the board's 7-segment driver.
- Samples the multiplexed scan bus (active-low one-hot digit enable plus segment pattern) and filters out transition glitches.
- Decodes each stable glyph back to a 4-bit digit value and keeps a per-position digit register file with validity flags.
- Used for loopback self-check of display paths and as a bus monitor in integration benches.

## Interface
- STABLE_CYCLES, 4: consecutive clocks a pair must hold before it is accepted; legal range 1..255.
- IDLE_CYCLES, 1_000_000: clocks with no accepted sample before all validity flags clear; legal range 2..2^24-1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- digit_enable  in  8  scan enable, active-low one-hot; bit i low selects position i; 8'hFF means blank.
- segment_data  in  8  active-high segments; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- digit_values  out  32  nibble i (bits 4i+3:4i) holds the last decoded value for position i.
- digit_valid  out  8  bit i set when position i holds a valid decode.
- sample_strobe  out  1  one-cycle pulse on each accepted, valid decode.
- last_num  out  4  value of the most recent valid decode.
- last_pos  out  3  position of the most recent valid decode.
- decode_err  out  1  one-cycle pulse on an accepted pair that is illegal.

## Operation
- Input stage: digit_enable and segment_data are registered together as one 16-bit pair (cap).
- Stability counter:
  - Compare cap against the previous cap each cycle.
  - On any difference, clear the counter and the accepted flag.
  - Otherwise increment the counter, saturating at STABLE_CYCLES.
- Acceptance: fires once per stable run, when the counter reaches STABLE_CYCLES with the accepted flag clear; acceptance sets the flag.
- Handling of an accepted pair:
  - Enable 8'hFF (blank): no output change and no strobe; the idle counter is not reset.
  - Enable with exactly one zero bit: pos is the index of that bit; decode segment_data using the glyph table.
  - Enable with two or more zero bits, or with no zero bit other than 8'hFF: pulse decode_err; no register update.
- Glyph table (segment_data -> value):
  - 8'h02 -> 0 (dash glyph used for zero) and 8'hFC -> 0.
  - 8'h60 -> 1, 8'hDA -> 2, 8'hF2 -> 3, 8'h66 -> 4.
  - 8'hB6 -> 5, 8'hBE -> 6, 8'hE0 -> 7, 8'hFE -> 8, 8'hF6 -> 9.
  - The dp bit is ignored only for the 8–9 entries; every other byte is illegal.
- Legal glyph: write nibble pos, set digit_valid[pos], load last_num and last_pos, pulse sample_strobe, reset the idle counter.
- Illegal glyph at a legal pos: clear digit_valid[pos], keep its nibble, pulse decode_err.
- Idle counter:
  - Increments every cycle and saturates.
  - On reaching IDLE_CYCLES, clear all digit_valid bits; digit_values are retained.
  - Must keep counting whenever no valid decode occurs, so one that reaches IDLE_CYCLES while a mid-run pair is still stabilising clears validity normally.
- Simultaneous idle expiry and a valid decode in the same cycle: the decode wins; its bit stays set and the counter restarts.

## Timing
- Reset values: digit_values=0, digit_valid=0, sample_strobe=0, decode_err=0, last_num=0, last_pos=0.
- Reset clears internal state: cap=16'hFFFF, stability counter=0, accepted flag=0, idle counter=0.
- Reset mid-run discards any partial stability count.
- A pair first present at rising edge k and held thereafter updates outputs at edge k+STABLE_CYCLES+1. Latency is STABLE_CYCLES+1 clocks.
- sample_strobe and decode_err are each high for exactly one cycle and are never high together.
- A pair held indefinitely produces exactly one acceptance.
- A change shorter than STABLE_CYCLES+1 edges is never accepted; an A->B->A bounce restarts the counter.

## Structure
- Shared package: SEG_* glyph constants (matching the driver's encoding), the blank-enable constant, and the bit-position constants for a..dp.
- One natural sub-module, seg_glyph_decode: combinational 8-bit pattern in -> 4-bit value plus legal flag.
- Everything else stays in the top level: capture, stability, idle, register file.

## Test plan
- Reset with STABLE_CYCLES=4: hold enable 8'hFE, seg 8'h60 for 10 cycles -> one strobe 5 clocks after first edge; digit_values[3:0]=1, digit_valid=8'h01, last_pos=0.
- Scan all eight positions with 8'h02, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0 -> digit_values=32'h76543210, digit_valid=8'hFF, eight strobes.
- Glitch pair held 3 cycles (shorter than the 5-edge acceptance window) between two valid pairs -> no strobe and no error for the glitch.
- Enable 8'hFC stable -> decode_err pulse and no value change; seg 8'h55 at pos 2 -> decode_err and digit_valid[2] cleared.
- IDLE_CYCLES=20:
  - After a full scan, drive 8'hFF only -> digit_valid becomes 0 at the 20th idle clock and digit_values unchanged.
  - Force a valid decode on the expiry cycle -> that position's bit remains 1.
- Assert rst_n low during a half-stable pair, then release -> all outputs at reset values and no strobe until a fresh 5-edge run.

Source files
------------

// File: rtl/segment_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan-bus monitor: glyph encodings,
// segment bit positions and the enable classification helper.
package segment_scan_decoder_pkg;

   localparam int SEG_A_BIT  = 7;
   localparam int SEG_B_BIT  = 6;
   localparam int SEG_C_BIT  = 5;
   localparam int SEG_D_BIT  = 4;
   localparam int SEG_E_BIT  = 3;
   localparam int SEG_F_BIT  = 2;
   localparam int SEG_G_BIT  = 1;
   localparam int SEG_DP_BIT = 0;

   localparam logic [7:0] SEG_DP_MASK = 8'(1 << SEG_DP_BIT);

   // Glyph encodings, identical to what the display driver emits.
   localparam logic [7:0] SEG_DASH = 8'h02;
   localparam logic [7:0] SEG_0    = 8'hFC;
   localparam logic [7:0] SEG_1    = 8'h60;
   localparam logic [7:0] SEG_2    = 8'hDA;
   localparam logic [7:0] SEG_3    = 8'hF2;
   localparam logic [7:0] SEG_4    = 8'h66;
   localparam logic [7:0] SEG_5    = 8'hB6;
   localparam logic [7:0] SEG_6    = 8'hBE;
   localparam logic [7:0] SEG_7    = 8'hE0;
   localparam logic [7:0] SEG_8    = 8'hFE;
   localparam logic [7:0] SEG_9    = 8'hF6;

   localparam logic [7:0] BLANK_ENABLE = 8'hFF;

   typedef enum logic [1:0] {
      EN_BLANK = 2'd0,
      EN_ONE   = 2'd1,
      EN_BAD   = 2'd2
   } enable_kind_e;

   typedef struct packed {
      enable_kind_e kind;
      logic [2:0]   pos;
   } enable_info_t;

   // Active-low enable: exactly one zero bit names a position, all ones is blank.
   function automatic enable_info_t classify_enable(input logic [7:0] en);
      enable_info_t info;
      int unsigned  zeros;
      info.kind = EN_BAD;
      info.pos  = 3'd0;
      zeros     = 0;
      for (int i = 0; i < 8; i++) begin
         if (!en[i]) begin
            zeros++;
            info.pos = 3'(i);
         end
      end
      if (en == BLANK_ENABLE) begin
         info.kind = EN_BLANK;
      end else if (zeros == 1) begin
         info.kind = EN_ONE;
      end
      return info;
   endfunction

endpackage

// File: rtl/segment_scan_decoder_glyph.sv
// Combinational glyph decoder: segment pattern back to a digit value.
// Only the 8 and 9 glyphs tolerate a lit decimal point.
module seg_glyph_decode
   import segment_scan_decoder_pkg::*;
(
   input  logic [7:0] pattern,
   output logic [3:0] value,
   output logic       legal
);

   always_comb begin
      value = 4'd0;
      legal = 1'b1;
      case (pattern)
         SEG_DASH, SEG_0:              value = 4'd0;
         SEG_1:                        value = 4'd1;
         SEG_2:                        value = 4'd2;
         SEG_3:                        value = 4'd3;
         SEG_4:                        value = 4'd4;
         SEG_5:                        value = 4'd5;
         SEG_6:                        value = 4'd6;
         SEG_7:                        value = 4'd7;
         SEG_8, SEG_8 | SEG_DP_MASK:   value = 4'd8;
         SEG_9, SEG_9 | SEG_DP_MASK:   value = 4'd9;
         default:                      legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/segment_scan_decoder.sv
// Scan-bus monitor: captures the multiplexed display bus, waits for a stable
// pair, decodes it and maintains a per-position digit register file.
module segment_scan_decoder
   import segment_scan_decoder_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned IDLE_CYCLES   = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  digit_enable,
   input  logic [7:0]  segment_data,
   output logic [31:0] digit_values,
   output logic [7:0]  digit_valid,
   output logic        sample_strobe,
   output logic [3:0]  last_num,
   output logic [2:0]  last_pos,
   output logic        decode_err
);

   localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES);
   localparam logic [23:0] IDLE_MAX = 24'(IDLE_CYCLES);

   logic [15:0] cap_q, cap_d;
   logic [15:0] prev_q, prev_d;
   logic [7:0]  stab_q, stab_d;
   logic        acc_q, acc_d;
   logic [23:0] idle_q, idle_d;
   logic [31:0] digit_values_q, digit_values_d;
   logic [7:0]  digit_valid_q, digit_valid_d;
   logic        sample_strobe_q, sample_strobe_d;
   logic        decode_err_q, decode_err_d;
   logic [3:0]  last_num_q, last_num_d;
   logic [2:0]  last_pos_q, last_pos_d;

   logic         same;
   logic         accept;
   logic         expire;
   enable_info_t en_info;
   logic [3:0]   glyph_value;
   logic         glyph_legal;

   seg_glyph_decode u_glyph (
      .pattern (cap_q[7:0]),
      .value   (glyph_value),
      .legal   (glyph_legal)
   );

   always_comb begin
      cap_d           = {digit_enable, segment_data};
      prev_d          = cap_q;
      stab_d          = stab_q;
      acc_d           = acc_q;
      idle_d          = idle_q;
      digit_values_d  = digit_values_q;
      digit_valid_d   = digit_valid_q;
      sample_strobe_d = 1'b0;
      decode_err_d    = 1'b0;
      last_num_d      = last_num_q;
      last_pos_d      = last_pos_q;
      en_info         = classify_enable(cap_q[15:8]);

      same = (cap_q == prev_q);
      if (!same) begin
         stab_d = 8'd0;
      end else if (stab_q >= STAB_MAX) begin
         stab_d = STAB_MAX;
      end else begin
         stab_d = stab_q + 8'd1;
      end

      // Acceptance lands on the same edge the counter reaches its target.
      accept = same && (stab_d == STAB_MAX) && !acc_q;
      acc_d  = same && (acc_q || accept);

      expire = (idle_q != IDLE_MAX) && ((idle_q + 24'd1) == IDLE_MAX);
      if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + 24'd1;
      end
      if (expire) begin
         digit_valid_d = 8'h00;
      end

      // Decode handling comes after expiry so a coincident valid decode wins.
      if (accept) begin
         case (en_info.kind)
            EN_ONE: begin
               if (glyph_legal) begin
                  digit_values_d[4*en_info.pos +: 4] = glyph_value;
                  digit_valid_d[en_info.pos]         = 1'b1;
                  last_num_d                         = glyph_value;
                  last_pos_d                         = en_info.pos;
                  sample_strobe_d                    = 1'b1;
                  idle_d                             = 24'd0;
               end else begin
                  digit_valid_d[en_info.pos] = 1'b0;
                  decode_err_d               = 1'b1;
               end
            end
            EN_BAD: begin
               decode_err_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q           <= 16'hFFFF;
         prev_q          <= 16'hFFFF;
         stab_q          <= 8'd0;
         acc_q           <= 1'b0;
         idle_q          <= 24'd0;
         digit_values_q  <= 32'd0;
         digit_valid_q   <= 8'd0;
         sample_strobe_q <= 1'b0;
         decode_err_q    <= 1'b0;
         last_num_q      <= 4'd0;
         last_pos_q      <= 3'd0;
      end else begin
         cap_q           <= cap_d;
         prev_q          <= prev_d;
         stab_q          <= stab_d;
         acc_q           <= acc_d;
         idle_q          <= idle_d;
         digit_values_q  <= digit_values_d;
         digit_valid_q   <= digit_valid_d;
         sample_strobe_q <= sample_strobe_d;
         decode_err_q    <= decode_err_d;
         last_num_q      <= last_num_d;
         last_pos_q      <= last_pos_d;
      end
   end

   assign digit_values  = digit_values_q;
   assign digit_valid   = digit_valid_q;
   assign sample_strobe = sample_strobe_q;
   assign decode_err    = decode_err_q;
   assign last_num      = last_num_q;
   assign last_pos      = last_pos_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder with STABLE_CYCLES=4, IDLE_CYCLES=20.
// Each hold counts strobes/errors and the edge index of the first strobe.
module tb_segment_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic [7:0]  digit_enable;
   logic [7:0]  segment_data;
   logic [31:0] digit_values;
   logic [7:0]  digit_valid;
   logic        sample_strobe;
   logic [3:0]  last_num;
   logic [2:0]  last_pos;
   logic        decode_err;

   int nTotal = 0;
   int nBad = 0;
   int strobeCount;
   int errCount;
   int firstStrobe;
   int bothCount = 0;

   logic [7:0] scanSeg [8] = '{8'h02, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0};

   segment_scan_decoder #(
      .STABLE_CYCLES (4),
      .IDLE_CYCLES   (20)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .digit_enable  (digit_enable),
      .segment_data  (segment_data),
      .digit_values  (digit_values),
      .digit_valid   (digit_valid),
      .sample_strobe (sample_strobe),
      .last_num      (last_num),
      .last_pos      (last_pos),
      .decode_err    (decode_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTotal++;
      if (got !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Waits n edges, sampling 1 time unit after each one.
   task automatic holdCount(input int n);
      strobeCount = 0;
      errCount    = 0;
      firstStrobe = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (sample_strobe === 1'b1) begin
            strobeCount++;
            if (firstStrobe == 0) firstStrobe = i;
         end
         if (decode_err === 1'b1) errCount++;
         if (sample_strobe === 1'b1 && decode_err === 1'b1) bothCount++;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] en, input logic [7:0] seg, input int n);
      digit_enable = en;
      segment_data = seg;
      holdCount(n);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_values"}, digit_values, 32'h0);
      checkOutput({tag, "_valid"}, {24'h0, digit_valid}, 32'h0);
      checkOutput({tag, "_strobe"}, {31'h0, sample_strobe}, 32'h0);
      checkOutput({tag, "_err"}, {31'h0, decode_err}, 32'h0);
      checkOutput({tag, "_lastNum"}, {28'h0, last_num}, 32'h0);
      checkOutput({tag, "_lastPos"}, {29'h0, last_pos}, 32'h0);
   endtask

   // Scans all eight positions with values 0..7, six edges each.
   task automatic scanAll(input string tag);
      logic [7:0] en;
      for (int i = 0; i < 8; i++) begin
         en = 8'(~(8'h01 << i));
         applyStimulus(en, scanSeg[i], 6);
         checkOutput($sformatf("%s_strobe%0d", tag, i), strobeCount, 1);
         checkOutput($sformatf("%s_lat%0d", tag, i), firstStrobe, 6);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      digit_enable = 8'hFF;
      segment_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst_n = 1'b1;
      holdCount(8);
      checkOutput("blankStrobe", strobeCount, 0);
      checkOutput("blankErr", errCount, 0);

      $display("[TB] single digit hold");
      applyStimulus(8'hFE, 8'h60, 10);
      checkOutput("oneStrobe", strobeCount, 1);
      checkOutput("oneLatency", firstStrobe, 6);
      checkOutput("oneValues", digit_values, 32'h0000_0001);
      checkOutput("oneValid", {24'h0, digit_valid}, 32'h01);
      checkOutput("oneLastPos", {29'h0, last_pos}, 32'h0);
      checkOutput("oneLastNum", {28'h0, last_num}, 32'h1);

      $display("[TB] full scan");
      scanAll("scan");
      checkOutput("scanValues", digit_values, 32'h7654_3210);
      checkOutput("scanValid", {24'h0, digit_valid}, 32'hFF);
      checkOutput("scanLastNum", {28'h0, last_num}, 32'h7);
      checkOutput("scanLastPos", {29'h0, last_pos}, 32'h7);

      $display("[TB] glitch rejection");
      applyStimulus(8'hFD, 8'h60, 6);
      checkOutput("preGlitchStrobe", strobeCount, 1);
      applyStimulus(8'hFD, 8'hF2, 3);
      checkOutput("glitchStrobe", strobeCount, 0);
      checkOutput("glitchErr", errCount, 0);
      applyStimulus(8'hFD, 8'h60, 6);
      checkOutput("postGlitchStrobe", strobeCount, 1);
      checkOutput("postGlitchLat", firstStrobe, 6);
      checkOutput("glitchValues", digit_values, 32'h7654_3210);

      $display("[TB] decimal point and zero glyphs");
      applyStimulus(8'hDF, 8'hF7, 6);
      checkOutput("dp9Strobe", strobeCount, 1);
      checkOutput("dp9LastNum", {28'h0, last_num}, 32'h9);
      applyStimulus(8'hBF, 8'hFC, 6);
      checkOutput("zeroStrobe", strobeCount, 1);
      checkOutput("zeroLastNum", {28'h0, last_num}, 32'h0);
      checkOutput("zeroLastPos", {29'h0, last_pos}, 32'h6);
      checkOutput("dpValues", digit_values, 32'h7094_3210);

      $display("[TB] illegal pairs");
      applyStimulus(8'hFC, 8'h60, 7);
      checkOutput("badEnErr", errCount, 1);
      checkOutput("badEnStrobe", strobeCount, 0);
      checkOutput("badEnValues", digit_values, 32'h7094_3210);
      checkOutput("badEnValid", {24'h0, digit_valid}, 32'hFF);
      applyStimulus(8'hFB, 8'h55, 7);
      checkOutput("badSegErr", errCount, 1);
      checkOutput("badSegStrobe", strobeCount, 0);
      checkOutput("badSegValid", {24'h0, digit_valid}, 32'hFB);
      checkOutput("badSegValues", digit_values, 32'h7094_3210);

      $display("[TB] idle expiry");
      scanAll("rescan");
      checkOutput("rescanValid", {24'h0, digit_valid}, 32'hFF);
      applyStimulus(8'hFF, 8'h00, 19);
      checkOutput("idle19Valid", {24'h0, digit_valid}, 32'hFF);
      checkOutput("idleBlankStrobe", strobeCount, 0);
      holdCount(1);
      checkOutput("idle20Valid", {24'h0, digit_valid}, 32'h00);
      checkOutput("idleValues", digit_values, 32'h7654_3210);

      $display("[TB] decode coincident with expiry");
      applyStimulus(8'hEF, 8'h66, 6);
      checkOutput("expP1Strobe", firstStrobe, 6);
      applyStimulus(8'hFF, 8'h00, 14);
      applyStimulus(8'hFB, 8'hF2, 6);
      checkOutput("expP2Strobe", strobeCount, 1);
      checkOutput("expP2Lat", firstStrobe, 6);
      checkOutput("expP2ValidBit", {31'h0, digit_valid[2]}, 32'h1);
      checkOutput("expP2Nibble", {28'h0, digit_values[11:8]}, 32'h3);

      $display("[TB] reset during a partial run");
      applyStimulus(8'hF7, 8'hB6, 3);
      checkOutput("partialStrobe", strobeCount, 0);
      rst_n = 1'b0;
      #1;
      checkResetState("midReset");
      rst_n = 1'b1;
      holdCount(8);
      checkOutput("afterResetStrobe", strobeCount, 1);
      checkOutput("afterResetLat", firstStrobe, 6);
      checkOutput("afterResetValues", digit_values, 32'h0000_5000);
      checkOutput("afterResetValid", {24'h0, digit_valid}, 32'h08);
      checkOutput("afterResetLastPos", {29'h0, last_pos}, 32'h3);
      checkOutput("afterResetLastNum", {28'h0, last_num}, 32'h5);

      checkOutput("strobeErrOverlap", bothCount, 0);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule
